// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer: state encoding and default width.
package countdown_timer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/down_count_reg.sv
// Loadable down-counting register. Load takes priority over decrement and the
// value saturates at zero so it can never wrap.
module down_count_reg
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             dec,
  output logic [WIDTH-1:0] value,
  output logic             is_one
);

  // Count register: load wins over decrement; decrement stops at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_data;
    end else if (dec && (value != '0)) begin
      value <= value - WIDTH'(1);
    end
  end

  assign is_one = (value == WIDTH'(1));

endmodule

// File: rtl/countdown_timer.sv
// Loadable down counter with start/stop/pause control, optional auto-reload
// and a one-cycle done pulse when the count reaches its terminal value.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] reload;
  logic             reload_we;
  logic             fire_done;
  logic             terminal;
  logic             cnt_load;
  logic [WIDTH-1:0] cnt_data;
  logic             cnt_dec;
  logic             cnt_is_one;

  down_count_reg #(
    .WIDTH(WIDTH)
  ) u_count (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_data(cnt_data),
    .dec      (cnt_dec),
    .value    (count),
    .is_one   (cnt_is_one)
  );

  // Terminal event in RUN: natural expiry at count 1, or a retrigger with a
  // zero period. stop always overrides it, and pause blocks only the natural
  // expiry (start outranks pause).
  assign terminal = (state == ST_RUN) && !stop &&
                    ((start && (load_val == '0)) ||
                     (!start && !pause && cnt_is_one));

  // Next-state and counter control, in priority order stop > start > pause > dec.
  always_comb begin
    next_state = state;
    reload_we  = 1'b0;
    fire_done  = 1'b0;
    cnt_load   = 1'b0;
    cnt_data   = '0;
    cnt_dec    = 1'b0;
    if (state == ST_IDLE) begin
      if (!stop && start) begin
        if (load_val != '0) begin
          cnt_load   = 1'b1;
          cnt_data   = load_val;
          reload_we  = 1'b1;
          next_state = ST_RUN;
        end else begin
          // Zero period: immediate done, count is already 0.
          fire_done = 1'b1;
        end
      end
    end else begin
      if (stop) begin
        cnt_load   = 1'b1;
        cnt_data   = '0;
        next_state = ST_IDLE;
      end else if (terminal) begin
        fire_done = 1'b1;
        cnt_load  = 1'b1;
        if (AUTO_RELOAD) begin
          // Reload register only ever holds a nonzero period while running.
          cnt_data = reload;
        end else begin
          cnt_data   = '0;
          next_state = ST_IDLE;
        end
      end else if (start) begin
        // Retrigger with a nonzero period; no done pulse.
        cnt_load  = 1'b1;
        cnt_data  = load_val;
        reload_we = 1'b1;
      end else if (!pause) begin
        cnt_dec = 1'b1;
      end
    end
  end

  // FSM state plus registered busy/done and the latched reload period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      reload <= '0;
    end else begin
      state <= next_state;
      busy  <= (next_state == ST_RUN);
      done  <= fire_done;
      if (reload_we) begin
        reload <= load_val;
      end
    end
  end

endmodule
